// File: rtl/forward_kinematics_pkg.sv
// rtl/forward_kinematics_pkg.sv - shared types, constants and number-format helpers for forward_kinematics
package forward_kinematics_pkg;

    localparam int N_WIDTH = 17;
    localparam int Q_WIDTH = 8;
    localparam int KV_Q16  = 594;
    localparam int KW_Q16  = 3600;

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_MUL, S_DONE} fk_state_t;
    typedef logic [N_WIDTH-1:0] sm_t;

    // Negative zero falls out as 0 because -0 == 0 in two's complement.
    function automatic logic signed [18:0] sm_to_tc(input sm_t v);
        logic signed [18:0] m;
        m = {3'b000, v[15:0]};
        return v[16] ? -m : m;
    endfunction

    function automatic logic [18:0] tc_to_sm(input logic signed [18:0] v);
        return {v[18], 18'(v[18] ? -v : v)};
    endfunction

endpackage

// File: rtl/forward_kinematics_if.sv
// rtl/forward_kinematics_if.sv - start/done request bus carrying wheel speeds in and body velocities out
interface forward_kinematics_if;
    import forward_kinematics_pkg::*;

    logic FORWARD_KINEMATICS_start_InHigh;
    sm_t  FORWARD_KINEMATICS_W1_InBus;
    sm_t  FORWARD_KINEMATICS_W2_InBus;
    sm_t  FORWARD_KINEMATICS_W3_InBus;
    sm_t  FORWARD_KINEMATICS_W4_InBus;
    sm_t  FORWARD_KINEMATICS_VX_OutBus;
    sm_t  FORWARD_KINEMATICS_VY_OutBus;
    sm_t  FORWARD_KINEMATICS_WZ_OutBus;
    logic FORWARD_KINEMATICS_done_OutHigh;
    logic FORWARD_KINEMATICS_busy_OutHigh;
    logic FORWARD_KINEMATICS_overflow_OutHigh;

    modport master (
        output FORWARD_KINEMATICS_start_InHigh, FORWARD_KINEMATICS_W1_InBus, FORWARD_KINEMATICS_W2_InBus,
               FORWARD_KINEMATICS_W3_InBus, FORWARD_KINEMATICS_W4_InBus,
        input  FORWARD_KINEMATICS_VX_OutBus, FORWARD_KINEMATICS_VY_OutBus, FORWARD_KINEMATICS_WZ_OutBus,
               FORWARD_KINEMATICS_done_OutHigh, FORWARD_KINEMATICS_busy_OutHigh, FORWARD_KINEMATICS_overflow_OutHigh
    );

    modport slave (
        input  FORWARD_KINEMATICS_start_InHigh, FORWARD_KINEMATICS_W1_InBus, FORWARD_KINEMATICS_W2_InBus,
               FORWARD_KINEMATICS_W3_InBus, FORWARD_KINEMATICS_W4_InBus,
        output FORWARD_KINEMATICS_VX_OutBus, FORWARD_KINEMATICS_VY_OutBus, FORWARD_KINEMATICS_WZ_OutBus,
               FORWARD_KINEMATICS_done_OutHigh, FORWARD_KINEMATICS_busy_OutHigh, FORWARD_KINEMATICS_overflow_OutHigh
    );

endinterface

// File: rtl/sc_seqmult_q16.sv
// rtl/sc_seqmult_q16.sv - 18x16 shift-add multiplier, one constant bit per cycle, Q16 round and 16-bit saturate
module sc_seqmult_q16 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [17:0] i_mag,
    input  logic [15:0] i_k,
    output logic        o_busy,
    output logic        o_last,
    output logic        o_done,
    output logic [15:0] o_result,
    output logic        o_ovf
);
    logic        r_run;
    logic        r_done;
    logic [3:0]  r_cnt;
    logic [33:0] r_acc;
    logic [3:0]  w_bit;
    logic [33:0] w_add;
    logic [18:0] w_q;

    // The start cycle already performs iteration 0, so a product spans exactly 16 edges.
    assign w_bit    = i_start ? 4'd0 : r_cnt;
    assign w_add    = i_k[w_bit] ? ({16'd0, i_mag} << w_bit) : 34'd0;
    assign w_q      = 19'(({1'b0, r_acc} + 35'h8000) >> 16);
    assign o_ovf    = |w_q[18:16];
    assign o_result = o_ovf ? 16'hFFFF : w_q[15:0];
    assign o_last   = r_run && (r_cnt == 4'd15);
    assign o_busy   = r_run;
    assign o_done   = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= 4'd0;
            r_acc  <= 34'd0;
        end else begin
            r_done <= o_last;
            if (i_start) begin
                r_acc <= w_add;
                r_cnt <= 4'd1;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_acc <= r_acc + w_add;
                r_cnt <= r_cnt + 4'd1;
                if (o_last) r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/forward_kinematics.sv
// rtl/forward_kinematics.sv - mecanum wheel speeds to body vx/vy/wz through one shared sequential multiplier
module forward_kinematics #(
    parameter int KV_Q16 = forward_kinematics_pkg::KV_Q16,
    parameter int KW_Q16 = forward_kinematics_pkg::KW_Q16
) (
    input logic           FORWARD_KINEMATICS_CLOCK_50,
    input logic           FORWARD_KINEMATICS_RESET_InLow,
    forward_kinematics_if.slave bus
);
    import forward_kinematics_pkg::*;

    localparam logic [15:0] KV = 16'(KV_Q16);
    localparam logic [15:0] KW = 16'(KW_Q16);

    fk_state_t r_state, w_next;
    sm_t r_w1, r_w2, r_w3, r_w4;
    sm_t r_vx, r_vy, r_out_vx, r_out_vy, r_out_wz;
    logic [2:0]  r_sgn;
    logic [17:0] r_mag_x, r_mag_y, r_mag_z;
    logic [1:0]  r_idx, w_op_idx;
    logic        r_ovf_acc, r_out_ovf, r_done;
    logic        w_mul_start, w_mul_busy, w_mul_last, w_mul_done, w_mul_ovf, w_sgn;
    logic [15:0] w_mul_res, w_k;
    logic [17:0] w_mag;
    logic signed [18:0] w_t1, w_t2, w_t3, w_t4;
    logic [18:0] w_sx, w_sy, w_sz;
    sm_t w_res_sm;

    assign w_t1 = sm_to_tc(r_w1);
    assign w_t2 = sm_to_tc(r_w2);
    assign w_t3 = sm_to_tc(r_w3);
    assign w_t4 = sm_to_tc(r_w4);
    assign w_sx = tc_to_sm(w_t1 + w_t2 + w_t3 + w_t4);
    assign w_sy = tc_to_sm(w_t2 + w_t3 - w_t1 - w_t4);
    assign w_sz = tc_to_sm(w_t2 + w_t4 - w_t1 - w_t3);

    // On the done cycle the next product starts at once, so look one index ahead.
    assign w_op_idx = w_mul_done ? r_idx + 2'd1 : r_idx;

    always_comb begin
        w_mag = r_mag_x;
        w_k   = KV;
        w_sgn = r_sgn[2];
        case (w_op_idx)
            2'd1:    w_mag = r_mag_y;
            2'd2:    begin w_mag = r_mag_z; w_k = KW; end
            default: ;
        endcase
        case (r_idx)
            2'd0:    w_sgn = r_sgn[0];
            2'd1:    w_sgn = r_sgn[1];
            default: ;
        endcase
    end

    assign w_res_sm = {w_sgn & (w_mul_res != 16'd0), w_mul_res};

    sc_seqmult_q16 u_mult (
        .i_clk    (FORWARD_KINEMATICS_CLOCK_50),
        .i_rst_n  (FORWARD_KINEMATICS_RESET_InLow),
        .i_start  (w_mul_start),
        .i_mag    (w_mag),
        .i_k      (w_k),
        .o_busy   (w_mul_busy),
        .o_last   (w_mul_last),
        .o_done   (w_mul_done),
        .o_result (w_mul_res),
        .o_ovf    (w_mul_ovf)
    );

    always_comb begin
        w_next      = r_state;
        w_mul_start = 1'b0;
        case (r_state)
            S_IDLE: if (bus.FORWARD_KINEMATICS_start_InHigh) w_next = S_SUM;
            S_SUM:  w_next = S_MUL;
            S_MUL: begin
                w_mul_start = !w_mul_busy;
                if (r_idx == 2'd2 && w_mul_last) w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge FORWARD_KINEMATICS_CLOCK_50 or negedge FORWARD_KINEMATICS_RESET_InLow) begin
        if (!FORWARD_KINEMATICS_RESET_InLow) begin
            r_state   <= S_IDLE;
            r_w1      <= '0;
            r_w2      <= '0;
            r_w3      <= '0;
            r_w4      <= '0;
            r_sgn     <= '0;
            r_mag_x   <= '0;
            r_mag_y   <= '0;
            r_mag_z   <= '0;
            r_idx     <= '0;
            r_vx      <= '0;
            r_vy      <= '0;
            r_out_vx  <= '0;
            r_out_vy  <= '0;
            r_out_wz  <= '0;
            r_ovf_acc <= 1'b0;
            r_out_ovf <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.FORWARD_KINEMATICS_start_InHigh) begin
                    r_w1      <= bus.FORWARD_KINEMATICS_W1_InBus;
                    r_w2      <= bus.FORWARD_KINEMATICS_W2_InBus;
                    r_w3      <= bus.FORWARD_KINEMATICS_W3_InBus;
                    r_w4      <= bus.FORWARD_KINEMATICS_W4_InBus;
                    r_idx     <= 2'd0;
                    r_ovf_acc <= 1'b0;
                end
                S_SUM: begin
                    r_sgn   <= {w_sz[18], w_sy[18], w_sx[18]};
                    r_mag_x <= w_sx[17:0];
                    r_mag_y <= w_sy[17:0];
                    r_mag_z <= w_sz[17:0];
                end
                S_MUL: if (w_mul_done) begin
                    if (r_idx == 2'd0) r_vx <= w_res_sm;
                    else               r_vy <= w_res_sm;
                    r_ovf_acc <= r_ovf_acc | w_mul_ovf;
                    r_idx     <= r_idx + 2'd1;
                end
                S_DONE: begin
                    r_out_vx  <= r_vx;
                    r_out_vy  <= r_vy;
                    r_out_wz  <= w_res_sm;
                    r_out_ovf <= r_ovf_acc | w_mul_ovf;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.FORWARD_KINEMATICS_VX_OutBus        = r_out_vx;
    assign bus.FORWARD_KINEMATICS_VY_OutBus        = r_out_vy;
    assign bus.FORWARD_KINEMATICS_WZ_OutBus        = r_out_wz;
    assign bus.FORWARD_KINEMATICS_done_OutHigh     = r_done;
    assign bus.FORWARD_KINEMATICS_overflow_OutHigh = r_out_ovf;
    assign bus.FORWARD_KINEMATICS_busy_OutHigh     = (r_state != S_IDLE);

endmodule

// File: tb/tb_forward_kinematics.sv
// tb/tb_forward_kinematics.sv - directed vectors against an arithmetic odometry model, two parameterisations
module tb_forward_kinematics;
    import forward_kinematics_pkg::*;

    localparam logic [16:0] ONE = 17'(1 << Q_WIDTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    forward_kinematics_if ifa ();
    forward_kinematics_if ifb ();

    forward_kinematics dut_a (
        .FORWARD_KINEMATICS_CLOCK_50    (clk),
        .FORWARD_KINEMATICS_RESET_InLow (rst_n),
        .bus                            (ifa)
    );

    forward_kinematics #(.KV_Q16(594), .KW_Q16(65535)) dut_b (
        .FORWARD_KINEMATICS_CLOCK_50    (clk),
        .FORWARD_KINEMATICS_RESET_InLow (rst_n),
        .bus                            (ifb)
    );

    int n_checks = 0;
    int n_fail = 0;
    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int kw_of [2] = '{3600, 65535};
    bit m_act [2];
    int m_e [2];
    logic [16:0] m_vx [2], m_vy [2], m_wz [2], p_vx [2], p_vy [2], p_wz [2];
    bit m_ov [2], p_ov [2];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at edge %0d", nm, d, act, exp, edges);
        end
    endtask

    function automatic longint sm2int(input logic [16:0] v);
        longint m;
        m = longint'(v[15:0]);
        return v[16] ? -m : m;
    endfunction

    function automatic logic [16:0] scale(input longint s, input longint k, output bit ov);
        longint mag, r;
        mag = (s < 0) ? -s : s;
        r = (mag * k + 32768) / 65536;
        ov = (r > 65535);
        if (ov) r = 65535;
        return {(s < 0) && (r != 0), r[15:0]};
    endfunction

    function automatic void fk_model(input logic [16:0] w1, w2, w3, w4, input longint kv, kw,
                                     output logic [16:0] vx, vy, wz, output bit ov);
        longint a1, a2, a3, a4;
        bit o1, o2, o3;
        a1 = sm2int(w1); a2 = sm2int(w2); a3 = sm2int(w3); a4 = sm2int(w4);
        vx = scale(a1 + a2 + a3 + a4, kv, o1);
        vy = scale(-a1 + a2 + a3 - a4, kv, o2);
        wz = scale(-a1 + a2 - a3 + a4, kw, o3);
        ov = o1 | o2 | o3;
    endfunction

    task automatic set_in(input int d, input logic st, input logic [16:0] a, b, c, e);
        if (d == 0) begin
            ifa.FORWARD_KINEMATICS_start_InHigh = st;
            ifa.FORWARD_KINEMATICS_W1_InBus = a; ifa.FORWARD_KINEMATICS_W2_InBus = b;
            ifa.FORWARD_KINEMATICS_W3_InBus = c; ifa.FORWARD_KINEMATICS_W4_InBus = e;
        end else begin
            ifb.FORWARD_KINEMATICS_start_InHigh = st;
            ifb.FORWARD_KINEMATICS_W1_InBus = a; ifb.FORWARD_KINEMATICS_W2_InBus = b;
            ifb.FORWARD_KINEMATICS_W3_InBus = c; ifb.FORWARD_KINEMATICS_W4_InBus = e;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_vx[d] = '0; m_vy[d] = '0; m_wz[d] = '0; m_ov[d] = 1'b0;
        end
    endtask

    // One start pulse; the model accepts it only if the block can be idle at that edge.
    task automatic pulse(input int d, input logic [16:0] w1, w2, w3, w4);
        @(negedge clk);
        set_in(d, 1'b1, w1, w2, w3, w4);
        @(posedge clk);
        #1;
        if (!m_act[d] || (edges - m_e[d] >= 51)) begin
            m_act[d] = 1'b1;
            m_e[d] = edges;
            fk_model(w1, w2, w3, w4, 594, kw_of[d], p_vx[d], p_vy[d], p_wz[d], p_ov[d]);
        end
        set_in(d, 1'b0, 17'($urandom), 17'($urandom), 17'($urandom), 17'($urandom));
    endtask

    task automatic check_dut(input int d);
        logic [16:0] avx, avy, awz;
        logic adone, abusy, aov;
        int rel;
        bit xd, xb;
        if (d == 0) begin
            avx = ifa.FORWARD_KINEMATICS_VX_OutBus; avy = ifa.FORWARD_KINEMATICS_VY_OutBus;
            awz = ifa.FORWARD_KINEMATICS_WZ_OutBus; adone = ifa.FORWARD_KINEMATICS_done_OutHigh;
            abusy = ifa.FORWARD_KINEMATICS_busy_OutHigh; aov = ifa.FORWARD_KINEMATICS_overflow_OutHigh;
        end else begin
            avx = ifb.FORWARD_KINEMATICS_VX_OutBus; avy = ifb.FORWARD_KINEMATICS_VY_OutBus;
            awz = ifb.FORWARD_KINEMATICS_WZ_OutBus; adone = ifb.FORWARD_KINEMATICS_done_OutHigh;
            abusy = ifb.FORWARD_KINEMATICS_busy_OutHigh; aov = ifb.FORWARD_KINEMATICS_overflow_OutHigh;
        end
        rel = edges - m_e[d];
        xd = m_act[d] && (rel == 50);
        xb = m_act[d] && (rel < 50);
        if (xd) begin
            m_vx[d] = p_vx[d]; m_vy[d] = p_vy[d]; m_wz[d] = p_wz[d]; m_ov[d] = p_ov[d];
            m_act[d] = 1'b0;
        end
        chk("done", d, adone, xd);
        chk("busy", d, abusy, xb);
        chk("vx", d, avx, m_vx[d]);
        chk("vy", d, avy, m_vy[d]);
        chk("wz", d, awz, m_wz[d]);
        chk("overflow", d, aov, m_ov[d]);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) check_dut(d);
    end

    task automatic pin_dut(input int d, input logic [16:0] vx, vy, wz, input logic ov);
        if (d == 0) begin
            chk("pin_vx", d, ifa.FORWARD_KINEMATICS_VX_OutBus, vx);
            chk("pin_vy", d, ifa.FORWARD_KINEMATICS_VY_OutBus, vy);
            chk("pin_wz", d, ifa.FORWARD_KINEMATICS_WZ_OutBus, wz);
            chk("pin_ovf", d, ifa.FORWARD_KINEMATICS_overflow_OutHigh, ov);
        end else begin
            chk("pin_vx", d, ifb.FORWARD_KINEMATICS_VX_OutBus, vx);
            chk("pin_vy", d, ifb.FORWARD_KINEMATICS_VY_OutBus, vy);
            chk("pin_wz", d, ifb.FORWARD_KINEMATICS_WZ_OutBus, wz);
            chk("pin_ovf", d, ifb.FORWARD_KINEMATICS_overflow_OutHigh, ov);
        end
    endtask

    // Pins both the model and the DUT to hand-computed results for one vector.
    task automatic run_pin(input int d, input logic [16:0] w1, w2, w3, w4,
                           input logic [16:0] evx, evy, ewz, input logic eov);
        logic [16:0] mvx, mvy, mwz;
        bit mov;
        fk_model(w1, w2, w3, w4, 594, kw_of[d], mvx, mvy, mwz, mov);
        chk("model_vx", d, mvx, evx);
        chk("model_vy", d, mvy, evy);
        chk("model_wz", d, mwz, ewz);
        chk("model_ovf", d, mov, eov);
        pulse(d, w1, w2, w3, w4);
        repeat (51) @(posedge clk);
        #1;
        pin_dut(d, evx, evy, ewz, eov);
    endtask

    logic [16:0] tbl [4][4];

    initial begin
        tbl[0] = '{17'h00100, 17'h00200, 17'h10080, 17'h00040};
        tbl[1] = '{17'h1ABCD, 17'h01234, 17'h0FFFF, 17'h10001};
        tbl[2] = '{17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF};
        tbl[3] = '{17'h1FFFF, 17'h10000, 17'h00001, 17'h1FFFF};
        set_in(0, 1'b0, '0, '0, '0, '0);
        set_in(1, 1'b0, '0, '0, '0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        pin_dut(0, '0, '0, '0, 1'b0);
        chk("rst_busy", 0, ifa.FORWARD_KINEMATICS_busy_OutHigh, 1'b0);
        chk("rst_done", 0, ifa.FORWARD_KINEMATICS_done_OutHigh, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pin(0, 17'h01B96, 17'h01B96, 17'h01B96, 17'h01B96, ONE, '0, '0, 1'b0);
        run_pin(0, 17'h11B96, 17'h01B96, 17'h01B96, 17'h11B96, '0, ONE, '0, 1'b0);
        run_pin(0, 17'h11B96, 17'h01B96, 17'h11B96, 17'h01B96, '0, '0, 17'h00610, 1'b0);
        run_pin(1, 17'h1FFFF, 17'h0FFFF, 17'h1FFFF, 17'h0FFFF, '0, '0, 17'h0FFFF, 1'b1);
        run_pin(1, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        run_pin(0, 17'h10000, 17'h10000, 17'h10000, 17'h10000, '0, '0, '0, 1'b0);
        run_pin(0, 17'h10001, '0, '0, '0, '0, '0, '0, 1'b0);
        run_pin(0, 17'h14000, '0, '0, '0, 17'h10095, 17'h00095, 17'h00384, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pulse(i % 2, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3]);
            repeat (52) @(posedge clk);
        end

        // Restarts mid-run must be ignored; the first vector's result must appear.
        pulse(0, 17'h01B96, 17'h01B96, 17'h01B96, 17'h01B96);
        repeat (4) @(posedge clk);
        pulse(0, 17'h11B96, 17'h01B96, 17'h01B96, 17'h11B96);
        repeat (24) @(posedge clk);
        pulse(0, 17'h11B96, 17'h01B96, 17'h01B96, 17'h11B96);
        repeat (22) @(posedge clk);
        #1;
        pin_dut(0, ONE, '0, '0, 1'b0);

        pulse(0, 17'h11B96, 17'h01B96, 17'h01B96, 17'h11B96);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        pin_dut(0, '0, '0, '0, 1'b0);
        chk("rst_mid_busy", 0, ifa.FORWARD_KINEMATICS_busy_OutHigh, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        run_pin(0, 17'h01B96, 17'h01B96, 17'h01B96, 17'h01B96, ONE, '0, '0, 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_kinematics.md
# forward_kinematics

Converts measured wheel angular velocities w1..w4 of the four-mecanum-wheel base into body velocities vx, vy, wz (odometry direction, inverse of the wheel-speed command path). Sits between the per-wheel encoder/speed estimators and the position/odometry integrator. Uses 17-bit sign-magnitude Q8 data throughout. Runs one shared sequential shift-add multiplier under a start/done handshake.

## Interface
- N_WIDTH, 17: data width, sign-magnitude; bit N_WIDTH-1 is the sign.
- Q_WIDTH, 8: fractional bits.
- KV_Q16, 594: r/4 as unsigned Q16 (r = 0.03625 m), 16 bits.
- KW_Q16, 3600: r/(4·k1) as unsigned Q16 (k1 = 0.165 m), 16 bits.
- FORWARD_KINEMATICS_CLOCK_50  in  1  system clock. One clock domain.
- FORWARD_KINEMATICS_RESET_InLow  in  1  reset, asynchronous, active-low.
- FORWARD_KINEMATICS_start_InHigh  in  1  one-cycle request, sampled only in IDLE.
- FORWARD_KINEMATICS_W1_InBus .. W4_InBus  in  N_WIDTH  wheel speeds in rad/s.
- FORWARD_KINEMATICS_VX_OutBus, VY_OutBus  out  N_WIDTH  body velocity in m/s.
- FORWARD_KINEMATICS_WZ_OutBus  out  N_WIDTH  yaw rate in rad/s.
- FORWARD_KINEMATICS_done_OutHigh  out  1  one-cycle pulse when the outputs update.
- FORWARD_KINEMATICS_busy_OutHigh  out  1  high in every state except IDLE.
- FORWARD_KINEMATICS_overflow_OutHigh  out  1  sticky per result set. Set if any of the three magnitudes saturated.

## Operation
- Equations:
  - vx = KV·(w1+w2+w3+w4)
  - vy = KV·(−w1+w2+w3−w4)
  - wz = KW·(−w1+w2−w3+w4)
- States: IDLE → SUM → MUL (3×16 cycles, index VX,VY,WZ) → DONE → IDLE.
- IDLE with start=1: latch W1..W4 into input registers, go to SUM. Start while busy is ignored; it is neither queued nor restarts the operation.
- SUM:
  - Convert each latched input to 19-bit two's complement. A negative zero converts to 0.
  - Form the three signed sums, magnitude ≤ 4·(2^16−1).
  - Store each sum as sign plus 18-bit magnitude.
- MUL:
  - Each product takes 16 cycles, processing constant bit i in iteration i.
  - Each iteration adds (magnitude << i) into a 34-bit accumulator when constant bit i is 1.
  - At the end of the 16 cycles: result = (acc + 2^15) >> 16, i.e. round half up on the magnitude.
  - If the result exceeds 2^16−1, saturate to 0xFFFF and set the overflow flag.
  - The result sign is the sum's sign, forced to 0 when the result magnitude is 0.
  - The accumulator clears between products.
- DONE:
  - Load VX/VY/WZ and overflow together and pulse done.
  - The new overflow value replaces the previous one.
  - Outputs then hold until the next DONE.
- Reset (any time, including mid-MUL): state IDLE, all output buses 0, done/busy/overflow 0, internal registers cleared.

## Timing
- Edge 0 samples start=1. busy is high from after edge 0 until after edge 50.
- Edge 1: SUM. Edges 2–49: MUL. Edge 50: outputs load and done rises; done falls at edge 51.
- Fixed latency: 50 clocks from start to done/valid outputs, independent of data.
- Earliest next accepted start: sampled at edge 51, giving a throughput of 1 result set per 51 cycles.
- Input buses may change after edge 0 without affecting the result.

## Structure
- Shared package holds:
  - the state enum (IDLE, SUM, MUL, DONE);
  - the default constants KV_Q16=594 and KW_Q16=3600;
  - the sign-magnitude ↔ two's-complement helper functions.
- Sub-module sc_seqmult_q16 is the 18×16 shift-add multiplier, with start, done, rounding and saturation. It is instantiated once and sequenced by the top-level FSM.

## Test plan
- All wheels = +0x01B96 (27.586 rad/s) → VX=0x00100 (1.0), VY=0, WZ=0, overflow=0; done exactly 50 cycles after start.
- W1=W4=−0x01B96 (0x11B96), W2=W3=+0x01B96 → VX=0, VY=0x00100, WZ=0.
- W1=W3=0x11B96, W2=W4=0x01B96 → VX=0, VY=0, WZ=0x00610 (6.0625 rad/s).
- Override KW_Q16=65535; W1=W3=0x1FFFF, W2=W4=0x0FFFF → WZ=0x0FFFF, overflow=1. A following all-zero run → overflow=0 and all outputs 0, including no negative zero.
- Start pulsed again at cycles 5 and 30 of a run → single done at cycle 50, result from the first inputs.
- Reset asserted at cycle 20 of a run → outputs 0, busy 0 immediately. No done after release; a new start then completes normally.
